// File: rtl/stop_it_gen.sv
// stop_it_gen: parametrised stop-the-counter reaction game on the 4 Hz clock.
// Inputs take effect on the next clk_4_i edge and all outputs decode registered state.
// There is no backpressure: go/stop/load are level inputs that the current state gates.
// Optional feature STOP_IT_LFSR_TARGET_EN draws the target from an LFSR instead of the switches.
module stop_it_gen #(
   parameter int         CNT_W           = 8,
   parameter logic [7:0] START_VAL       = 8'h1F,
   parameter int         GO_WAIT_CYC     = 8,
   parameter int         RESULT_WAIT_CYC = 16,
   parameter int         DEC_DIV         = 1,
   parameter int         WIN_SCORE       = 17,
   parameter int         MAX_MISSES      = 0
) (
   input  logic        clk_4_i,
   input  logic        rst_i,
   input  logic        go_i,
   input  logic        stop_i,
   input  logic        load_i,
   input  logic [15:0] switches_i,
   output logic [15:0] leds_o,
   output logic        digit0_en_o,
   output logic        digit1_en_o,
   output logic        digit2_en_o,
   output logic        digit3_en_o,
   output logic [3:0]  digit0_o,
   output logic [3:0]  digit1_o,
   output logic [3:0]  digit2_o,
   output logic [3:0]  digit3_o,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      WAITING_TO_START = 3'd0,
      STARTING         = 3'd1,
      DECREMENTING     = 3'd2,
      CORRECT          = 3'd3,
      WRONG            = 3'd4,
      WON              = 3'd5,
      LOST             = 3'd6
   } state_t;

   localparam int MAX_WAIT = (GO_WAIT_CYC > RESULT_WAIT_CYC) ?
                             ((GO_WAIT_CYC > DEC_DIV) ? GO_WAIT_CYC : DEC_DIV) :
                             ((RESULT_WAIT_CYC > DEC_DIV) ? RESULT_WAIT_CYC : DEC_DIV);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] GO_LAST  = WAIT_W'(GO_WAIT_CYC - 1);
   localparam logic [WAIT_W-1:0] RES_LAST = WAIT_W'(RESULT_WAIT_CYC - 1);
   localparam logic [WAIT_W-1:0] DEC_LAST = WAIT_W'(DEC_DIV - 1);
   localparam logic [CNT_W-1:0]  START_T  = START_VAL[CNT_W-1:0];
   localparam logic [7:0]        WIN_L    = 8'(WIN_SCORE);
   localparam logic [7:0]        MISS_L   = 8'(MAX_MISSES);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  target, target_nxt;
   logic [7:0]        score, score_nxt;
   logic [7:0]        misses, misses_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              blink, blink_nxt;
   logic [7:0]        cnt8, tgt8;
   logic              en_lo, en_hi;
   logic              unused_in;

   function automatic logic blinks(input state_t s);
      return (s == CORRECT) || (s == WRONG) || (s == WON) || (s == LOST);
   endfunction

`ifdef STOP_IT_LFSR_TARGET_EN
   logic [7:0]       lfsr;
   logic [CNT_W:0]   lfsr_ext;
   logic [CNT_W-1:0] lfsr_tgt;

   assign lfsr_ext  = {1'b0, lfsr[CNT_W-1:0]};
   // Values above START_VAL could never be displayed by the counter, so fold them into range.
   assign lfsr_tgt  = (lfsr_ext > {1'b0, START_T}) ?
                      CNT_W'(lfsr_ext % ({1'b0, START_T} + (CNT_W+1)'(1))) : lfsr[CNT_W-1:0];
   assign unused_in = load_i ^ (^switches_i);

   always_ff @(posedge clk_4_i or posedge rst_i) begin
      if (rst_i) lfsr <= 8'h01;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`else
   assign unused_in = ^switches_i[15:CNT_W];
`endif

   always_ff @(posedge clk_4_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= WAITING_TO_START;
         cnt      <= START_T;
         target   <= '0;
         score    <= '0;
         misses   <= '0;
         wait_cnt <= '0;
         blink    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         target   <= target_nxt;
         score    <= score_nxt;
         misses   <= misses_nxt;
         wait_cnt <= wait_nxt;
         blink    <= blink_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      target_nxt = target;
      score_nxt  = score;
      misses_nxt = misses;
      wait_nxt   = wait_cnt;
      case (state)
         WAITING_TO_START: begin
`ifdef STOP_IT_LFSR_TARGET_EN
            if (go_i) target_nxt = lfsr_tgt;
`else
            if (load_i) target_nxt = switches_i[CNT_W-1:0];
`endif
            if (go_i) begin
               state_nxt = STARTING;
               wait_nxt  = '0;
            end
         end
         STARTING: begin
            if (wait_cnt == GO_LAST) begin
               state_nxt = DECREMENTING;
               cnt_nxt   = START_T;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         DECREMENTING: begin
            // A stop wins over a decrement due on the same edge, freezing the compared value.
            if (stop_i) begin
               state_nxt = (cnt == target) ? CORRECT : WRONG;
               wait_nxt  = '0;
            end else if (wait_cnt == DEC_LAST) begin
               wait_nxt = '0;
               cnt_nxt  = (cnt == '0) ? START_T : cnt - CNT_W'(1);
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         CORRECT: begin
            if (wait_cnt == RES_LAST) begin
               score_nxt = score + 8'd1;
               state_nxt = (score_nxt == WIN_L) ? WON : WAITING_TO_START;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         WRONG: begin
            if (wait_cnt == RES_LAST) begin
               misses_nxt = misses + 8'd1;
               state_nxt  = ((MAX_MISSES != 0) && (misses_nxt == MISS_L)) ? LOST : WAITING_TO_START;
               wait_nxt   = '0;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         default: ;
      endcase
      // Blink phase runs continuously across CORRECT->WON and restarts at 0 on entry.
      blink_nxt = (blinks(state_nxt) && blinks(state)) ? ~blink : 1'b0;
   end

   assign cnt8     = 8'(cnt);
   assign tgt8     = 8'(target);
   assign digit0_o = cnt8[3:0];
   assign digit1_o = cnt8[7:4];
   assign digit2_o = tgt8[3:0];
   assign digit3_o = tgt8[7:4];
   assign state_o  = state;

   assign digit0_en_o = en_lo;
   assign digit1_en_o = en_lo;
   assign digit2_en_o = en_hi;
   assign digit3_en_o = en_hi;

   always_comb begin
      en_lo  = 1'b1;
      en_hi  = 1'b1;
      leds_o = '0;
      case (state)
         CORRECT, WRONG: en_lo = ~blink;
         WON, LOST: begin
            en_lo = ~blink;
            en_hi = ~blink;
         end
         default: ;
      endcase
      for (int i = 0; i < 16; i++) leds_o[i] = (score > 8'(i));
      if (state == WON) leds_o = blink ? 16'h0000 : 16'hFFFF;
   end

endmodule

// File: tb/tb_stop_it_gen.sv
// Bench for stop_it_gen: directed rounds plus randomized play, scored every cycle against a
// timing-based game model (counter value derived from time spent decrementing).
module tb_stop_it_gen;

   localparam int CW      = 8;
   localparam int START   = 'h1F;
   localparam int GO_CYC  = 8;
   localparam int RES_CYC = 16;
   localparam int DD      = 2;
   localparam int WIN     = 17;
   localparam int MM      = 3;

   logic        clk_4_i = 1'b0;
   logic        rst_i   = 1'b1;
   logic        go_i, stop_i, load_i;
   logic [15:0] switches_i;
   logic [15:0] leds_o;
   logic        digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o;
   logic [3:0]  digit0_o, digit1_o, digit2_o, digit3_o;
   logic [2:0]  state_o;
   logic [15:0] dig_all;
   logic [3:0]  en_all;

   stop_it_gen #(
      .CNT_W(CW), .START_VAL(8'h1F), .GO_WAIT_CYC(GO_CYC), .RESULT_WAIT_CYC(RES_CYC),
      .DEC_DIV(DD), .WIN_SCORE(WIN), .MAX_MISSES(MM)
   ) dut (
      .clk_4_i(clk_4_i), .rst_i(rst_i), .go_i(go_i), .stop_i(stop_i), .load_i(load_i),
      .switches_i(switches_i), .leds_o(leds_o),
      .digit0_en_o(digit0_en_o), .digit1_en_o(digit1_en_o),
      .digit2_en_o(digit2_en_o), .digit3_en_o(digit3_en_o),
      .digit0_o(digit0_o), .digit1_o(digit1_o), .digit2_o(digit2_o), .digit3_o(digit3_o),
      .state_o(state_o)
   );

   always #5 clk_4_i = ~clk_4_i;

   assign dig_all = {digit3_o, digit2_o, digit1_o, digit0_o};
   assign en_all  = {digit3_en_o, digit2_en_o, digit1_en_o, digit0_en_o};

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   // Game model: state number, cycles spent in it, and the blink-region age.
   int m_st = 0, m_el = 0, m_tgt = 0, m_cnt = START, m_score = 0, m_miss = 0, m_age = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cnt_now();
      if (m_st == 2) return START - ((m_el / DD) % (START + 1));
      return m_cnt;
   endfunction

   function automatic bit blinky(input int s);
      return (s >= 3) && (s <= 6);
   endfunction

   always @(posedge clk_4_i or posedge rst_i) begin
      if (rst_i) begin
         m_st = 0; m_el = 0; m_tgt = 0; m_cnt = START; m_score = 0; m_miss = 0; m_age = 0;
      end else begin : step
         int nst;
         nst = m_st;
         case (m_st)
            0: begin
               if (load_i) m_tgt = int'(switches_i[7:0]);
               if (go_i) nst = 1;
            end
            1: if (m_el == GO_CYC - 1) begin nst = 2; m_cnt = START; end
            2: if (stop_i) begin
               m_cnt = cnt_now();
               nst = (m_cnt == m_tgt) ? 3 : 4;
            end
            3: if (m_el == RES_CYC - 1) begin
               m_score++;
               nst = (m_score == WIN) ? 5 : 0;
            end
            4: if (m_el == RES_CYC - 1) begin
               m_miss++;
               nst = ((MM != 0) && (m_miss == MM)) ? 6 : 0;
            end
            default: ;
         endcase
         m_age = blinky(nst) ? (blinky(m_st) ? m_age + 1 : 0) : 0;
         m_el  = (nst != m_st) ? 0 : m_el + 1;
         m_st  = nst;
      end
   end

   always @(negedge clk_4_i) begin
      if (chk_en) begin : cmp
         bit          b;
         logic [3:0]  ee;
         logic [15:0] el;
         logic [15:0] ed;
         b  = (m_age % 2) == 1;
         ed = {8'(m_tgt), 8'(cnt_now())};
         case (m_st)
            3, 4:    ee = {2'b11, ~b, ~b};
            5, 6:    ee = {4{~b}};
            default: ee = 4'hF;
         endcase
         if (m_st == 5)         el = b ? 16'h0000 : 16'hFFFF;
         else if (m_score >= 16) el = 16'hFFFF;
         else                   el = 16'((32'd1 << m_score) - 1);
         chk("cyc_state", 32'(state_o), 32'(m_st));
         chk("cyc_digits", 32'(dig_all), 32'(ed));
         chk("cyc_enables", 32'(en_all), 32'(ee));
         chk("cyc_leds", 32'(leds_o), 32'(el));
      end
   end

   task automatic tick(input logic go, input logic stop, input logic load, input logic [15:0] sw);
      go_i = go; stop_i = stop; load_i = load; switches_i = sw;
      @(negedge clk_4_i);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic noise();
      tick(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
   endtask

   task automatic play_round(input bit want_wrong);
      logic [15:0] sw;
      int guard;
      repeat ($urandom_range(0, 3)) begin
         sw = 16'($urandom); sw[7:0] = 8'($urandom_range(0, 31));
         tick(1'b0, 1'($urandom), 1'($urandom), sw);
      end
      sw = 16'($urandom); sw[7:0] = 8'($urandom_range(0, 31));
      tick(1'b1, 1'($urandom), 1'($urandom), sw);
      guard = 0;
      while (m_st == 1 && guard < 20) begin noise(); guard++; end
      chk("round_dec", 32'(state_o), 32'd2);
      guard = 0;
      while (m_st == 2 && guard < 200) begin : dec_loop
         bit s;
         if (want_wrong) s = (cnt_now() != m_tgt) && ((guard > 8) || ($urandom_range(0, 3) == 0));
         else            s = (cnt_now() == m_tgt);
         tick(1'($urandom), s, 1'($urandom), 16'($urandom));
         guard++;
      end
      chk("round_result", 32'(state_o), want_wrong ? 32'd4 : 32'd3);
      guard = 0;
      while ((m_st == 3 || m_st == 4) && guard < 40) begin noise(); guard++; end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      go_i = 0; stop_i = 0; load_i = 0; switches_i = 0;
      @(negedge clk_4_i);
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_leds", 32'(leds_o), 32'h0);
      chk("rst_en", 32'(en_all), 32'hF);
      chk("rst_digits", 32'(dig_all), 32'h001F);
      chk_en = 1;
      rst_i  = 0;

      // Correct round: target 0x10, counter reaches it after 30 cycles at DEC_DIV=2.
      tick(1'b0, 1'b0, 1'b1, 16'hAB10);
      chk("load_digits", 32'(dig_all), 32'h101F);
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
      chk("go_start", 32'(state_o), 32'd1);
      idle(7);
      chk("start_hold", 32'(state_o), 32'd1);
      idle(1);
      chk("dec_entry", 32'(state_o), 32'd2);
      chk("dec_entry_cnt", 32'(dig_all), 32'h101F);
      idle(1);
      chk("dec_k1", 32'(dig_all), 32'h101F);
      idle(1);
      chk("dec_k2", 32'(dig_all), 32'h101E);
      idle(28);
      chk("dec_k30", 32'(dig_all), 32'h1010);
      tick(1'b0, 1'b1, 1'b0, 16'h0000);
      chk("correct", 32'(state_o), 32'd3);
      chk("correct_en0", 32'(en_all), 32'hF);
      idle(1);
      chk("correct_en1", 32'(en_all), 32'hC);
      idle(14);
      chk("correct_hold", 32'(state_o), 32'd3);
      idle(1);
      chk("correct_done", 32'(state_o), 32'd0);
      chk("score1_leds", 32'(leds_o), 32'h0001);

      // Wrong round: stop at 0x11.
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
      idle(8);
      idle(28);
      chk("dec_k28", 32'(dig_all), 32'h1011);
      tick(1'b0, 1'b1, 1'b0, 16'h0000);
      chk("wrong", 32'(state_o), 32'd4);
      idle(16);
      chk("wrong_done", 32'(state_o), 32'd0);
      chk("wrong_leds", 32'(leds_o), 32'h0001);
      chk("wrong_frozen", 32'(dig_all), 32'h1011);

      // Underflow wraps to START_VAL.
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
      idle(8);
      idle(62);
      chk("cnt_zero", 32'(dig_all), 32'h1000);
      idle(1);
      chk("cnt_zero_hold", 32'(dig_all), 32'h1000);
      idle(1);
      chk("cnt_wrap", 32'(dig_all), 32'h101F);
      tick(1'b0, 1'b1, 1'b0, 16'h0000);
      idle(16);
      chk("two_misses_wait", 32'(state_o), 32'd0);

      // Randomized play to WON.
      rst_i = 1;
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("rst2_state", 32'(state_o), 32'd0);
      chk("rst2_leds", 32'(leds_o), 32'h0);
      rst_i = 0;
      for (int r = 0; r < 40 && m_st != 5; r++)
         play_round((m_miss < MM - 1) && ($urandom_range(0, 3) == 0));
      chk("won", 32'(state_o), 32'd5);
      repeat (6) tick(1'b1, 1'b1, 1'b1, 16'h0005);
      chk("won_sticky", 32'(state_o), 32'd5);
      rst_i = 1;
      #1;
      chk("won_rst_state", 32'(state_o), 32'd0);
      chk("won_rst_leds", 32'(leds_o), 32'h0);
      chk("won_rst_en", 32'(en_all), 32'hF);
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
      rst_i = 0;

      // Three misses lose the game.
      tick(1'b0, 1'b0, 1'b1, 16'h0010);
      repeat (3) play_round(1'b1);
      chk("lost", 32'(state_o), 32'd6);
      repeat (5) noise();
      chk("lost_sticky", 32'(state_o), 32'd6);

      // Async reset mid-DECREMENTING.
      rst_i = 1;
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
      rst_i = 0;
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
      idle(8 + 5);
      chk("pre_rst_dec", 32'(state_o), 32'd2);
      rst_i = 1;
      #1;
      chk("async_rst_state", 32'(state_o), 32'd0);
      chk("async_rst_digits", 32'(dig_all), 32'h001F);
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
      rst_i = 0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
